fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
- Instruction fetch stage: owns the program counter and issues word fetches to instruction memory over a req/ack handshake.
- Holds each fetched word in a one-entry output buffer toward decode.
- Computes redirect targets internally from raw fields: 16-bit branch immediate sign-extended and shifted left 2 and added to PC+4; 26-bit jump field; register target.
- Sits directly upstream of decode. Replaces the bare PC flop plus external sign-extend, shift and adder path.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- PC_W, 32, PC/address width; only 32 supported.

Ports:
- clk  input  1  clock; all state on posedge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; held until ack.
- imem_addr  output  32  word address; stable while imem_req=1.
- imem_ack  input  1  fetch complete this cycle; imem_rdata valid.
- imem_rdata  input  32  instruction word.
- if_valid  output  1  output buffer holds an instruction.
- if_instr  output  32  buffered instruction.
- if_pc  output  32  address of if_instr.
- if_pc4  output  32  if_pc + 4.
- id_ready  input  1  decode accepts when if_valid && id_ready.
- redir_valid  input  1  redirect request, one-cycle pulse.
- redir_sel  input  2  00 branch, 01 jump, 10 register, 11 ignored.
- redir_base  input  32  PC+4 of the redirecting instruction.
- redir_imm  input  26  jump field; bits [15:0] are the branch immediate.
- redir_reg  input  32  register target.

Behaviour:
- Reset (synchronous, active-high) has priority over everything:
  - pc <= RESET_PC; state <= FETCH.
  - if_valid=0; if_instr, if_pc, if_pc4 = 0.
  - imem_req=0 in the reset cycle.
  - Reset mid-wait abandons the outstanding fetch; an ack arriving in the reset cycle is ignored.
- Targets, 32-bit wrap-around arithmetic, no overflow detection:
  - branch = redir_base + ({{16{imm[15]}}, imm[15:0]} << 2)
  - jump = {redir_base[31:28], redir_imm, 2'b00}
  - reg = redir_reg
  - sel 11: no redirect, pulse has no effect.
- State FETCH:
  - imem_req=1, imem_addr=pc.
  - On ack: capture rdata/pc/pc+4 into the buffer, if_valid<=1, pc<=pc+4, go to HOLD.
  - No ack: stay in FETCH with address unchanged.
  - Zero-wait memory (ack in the same cycle) gives 1-cycle latency from req to if_valid.
- State HOLD:
  - imem_req=0; buffer stable.
  - On id_ready: if_valid<=0 and go to FETCH. No buffer bypass, so peak throughput is one instruction per 2 cycles.
- Redirect (valid sel), any state:
  - pc <= target.
  - Buffer flushed: if_valid<=0 the next cycle, even if id_ready is high in the same cycle; the consumed-vs-flushed choice is decided by flush.
  - In FETCH without ack: request withdrawn; next cycle requests the target. Memory must tolerate a withdrawn request.
  - In FETCH with ack in the same cycle: fetched word discarded.
  - Next state is FETCH.
- Misaligned redir_reg: bits [1:0] forced to 0.
- pc+4 at 32'hFFFF_FFFC wraps to 0.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined:
  - Adds outputs perf_fetched[31:0] (acks accepted into the buffer) and perf_flushed[31:0] (buffered or acked words discarded by redirect).
  - Both counters cleared by reset, wrap at 2^32.
- When undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package fetch_pkg:
  - REDIR_BRANCH=2'b00, REDIR_JUMP=2'b01, REDIR_REG=2'b10.
  - State encoding FETCH=1'b0, HOLD=1'b1.
  - Constant PC_STEP=32'd4.
- One sub-module next_pc_calc: purely combinational redirect target from sel/base/imm/reg, unit-testable standalone.

Test Plan:
- Reset with RESET_PC=32'h100, zero-wait memory, id_ready=1 -> imem_addr sequence 100, 104, 108 on alternating cycles; if_pc matches; if_pc4 = if_pc+4.
- ack delayed 3 cycles at addr 0x200 -> imem_req high and imem_addr=0x200 for 4 cycles; if_valid exactly 1 cycle after ack.
- Branch with base=0x1004, imm16=16'hFFFE -> next imem_addr=0x0FFC; imm16=16'h0003 -> 0x1010.
- Jump with base=0x4000_0010, imm=26'h0000040 -> 0x4000_0100. sel=11 -> pc unchanged.
- Redirect in the same cycle as ack with if_valid=0 -> word discarded, if_valid stays 0, next request at target (perf_flushed +1 if enabled).
- Reset asserted while in FETCH awaiting ack, ack arrives during reset -> if_valid=0, next request at RESET_PC.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// rtl/fetch_pc_unit_pkg.sv - shared encodings and constants for the fetch stage
package fetch_pkg;
  localparam logic [1:0] REDIR_BRANCH = 2'b00;
  localparam logic [1:0] REDIR_JUMP   = 2'b01;
  localparam logic [1:0] REDIR_REG    = 2'b10;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - instruction memory req/ack bus between fetch and imem
interface fetch_pc_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_pc_unit_next_pc_calc.sv
// rtl/fetch_pc_unit_next_pc_calc.sv - combinational redirect target from raw fields
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic [31:0] base,
  input  logic [25:0] imm,
  input  logic [31:0] reg_tgt,
  output logic [31:0] target,
  output logic        valid
);
  always_comb begin
    target = '0;
    valid  = 1'b1;
    case (sel)
      REDIR_BRANCH: target = base + {{14{imm[15]}}, imm[15:0], 2'b00};
      REDIR_JUMP:   target = {base[31:28], imm, 2'b00};
      REDIR_REG:    target = reg_tgt & 32'hFFFF_FFFC;
      default:      valid  = 1'b0;
    endcase
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - PC owner, imem fetch FSM and one-entry buffer toward decode
// Optional FETCH_PERF_EN adds fetched/flushed event counters.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  fetch_pc_unit_if.master   imem,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [PC_W-1:0]   if_pc,
  output logic [PC_W-1:0]   if_pc4,
  input  logic              id_ready,
  input  logic              redir_valid,
  input  logic [1:0]        redir_sel,
  input  logic [PC_W-1:0]   redir_base,
  input  logic [25:0]       redir_imm,
  input  logic [PC_W-1:0]   redir_reg
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed
`endif
);
  fetch_state_e    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] target;
  logic            target_ok;
  logic            redir_take;
  logic            fetch_ack;

  next_pc_calc u_next_pc_calc (
    .sel     (redir_sel),
    .base    (redir_base),
    .imm     (redir_imm),
    .reg_tgt (redir_reg),
    .target  (target),
    .valid   (target_ok)
  );

  assign redir_take     = redir_valid & target_ok;
  assign fetch_ack      = (state == FETCH) & imem.imem_ack;
  // Reset is folded in so no request is visible during the reset cycle itself.
  assign imem.imem_req  = (state == FETCH) & ~reset;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      state    <= FETCH;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
      if_pc4   <= '0;
`ifdef FETCH_PERF_EN
      perf_fetched <= '0;
      perf_flushed <= '0;
`endif
    end else if (redir_take) begin
      // Flush wins over a same-cycle consume or ack.
      pc       <= target;
      state    <= FETCH;
      if_valid <= 1'b0;
`ifdef FETCH_PERF_EN
      if (if_valid || fetch_ack) perf_flushed <= perf_flushed + 32'd1;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (imem.imem_ack) begin
            if_instr <= imem.imem_rdata;
            if_pc    <= pc;
            if_pc4   <= pc + PC_STEP;
            if_valid <= 1'b1;
            pc       <= pc + PC_STEP;
            state    <= HOLD;
`ifdef FETCH_PERF_EN
            perf_fetched <= perf_fetched + 32'd1;
`endif
          end
        end
        HOLD: begin
          if (id_ready) begin
            if_valid <= 1'b0;
            state    <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end
endmodule
